warp_mask_pipe_elastic: RTL and testbench

Elastic, parametrised successor to the single-stage warp active-mask register. It accepts one warp mask per cycle under a valid/ready handshake and carries it with its warp ID through STAGES register stages. It produces popcount, first/last active lane and any/all flags for each mask. It sits between the warp scheduler and the issue/operand-collect stage, and it supports backpressure.

---
 rtl/warp_mask_pkg.sv | 29 ++
 rtl/warp_mask_pipe_elastic_reduce.sv | 34 +++
 rtl/warp_mask_pipe_elastic.sv | 138 +++++++++++++
 tb/tb_warp_mask_pipe_elastic.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/warp_mask_pkg.sv
// Shared types and width helpers for the warp active-mask pipeline.
// The payload struct is sized for the largest supported warp; users slice the live bits.
package warp_mask_pkg;

    localparam int STAT_W        = 32;
    localparam int MAX_WARP_SIZE = 64;
    localparam int MAX_LANE_W    = 6;
    localparam int MAX_CNT_W     = 7;
    localparam int MAX_WARP_ID_W = 16;

    function automatic int f_lane_w(input int warp_size);
        return $clog2(warp_size);
    endfunction

    function automatic int f_cnt_w(input int warp_size);
        return $clog2(warp_size + 1);
    endfunction

    typedef struct packed {
        logic [MAX_WARP_ID_W-1:0] warp_id;
        logic [MAX_WARP_SIZE-1:0] mask;
        logic [MAX_CNT_W-1:0]     count;
        logic [MAX_LANE_W-1:0]    first;
        logic [MAX_LANE_W-1:0]    last;
        logic                     any;
        logic                     all;
    } warp_payload_t;

endpackage

// File: rtl/warp_mask_pipe_elastic_reduce.sv
// Combinational mask reduction: popcount, find-first, find-last, any/all.
// An empty mask reports first = last = 0.
module warp_mask_reduce
    import warp_mask_pkg::*;
#(
    parameter int WARP_SIZE = 32,
    parameter int LANE_W    = f_lane_w(WARP_SIZE),
    parameter int CNT_W     = f_cnt_w(WARP_SIZE)
) (
    input  logic [WARP_SIZE-1:0] i_mask,
    output logic [CNT_W-1:0]     o_count,
    output logic [LANE_W-1:0]    o_first,
    output logic [LANE_W-1:0]    o_last,
    output logic                 o_any,
    output logic                 o_all
);

    always_comb begin
        o_count = '0;
        o_first = '0;
        o_last  = '0;
        for (int i = 0; i < WARP_SIZE; i++) begin
            o_count = o_count + CNT_W'(i_mask[i]);
            if (i_mask[i]) o_last = LANE_W'(i);
        end
        for (int i = WARP_SIZE - 1; i >= 0; i--) begin
            if (i_mask[i]) o_first = LANE_W'(i);
        end
    end

    assign o_any = |i_mask;
    assign o_all = &i_mask;

endmodule

// File: rtl/warp_mask_pipe_elastic.sv
// Elastic STAGES-deep warp-mask pipeline with reduction results in stage 0.
// Optional lane/warp statistics counters: define WARP_MASK_STATS_EN.
module warp_mask_pipe_elastic
    import warp_mask_pkg::*;
#(
    parameter int WARP_SIZE = 32,
    parameter int WARP_ID_W = 4,
    parameter int STAGES    = 2,
    parameter int LANE_W    = f_lane_w(WARP_SIZE),
    parameter int CNT_W     = f_cnt_w(WARP_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WARP_ID_W-1:0] in_warp_id,
    input  logic [WARP_SIZE-1:0] in_mask,
    input  logic [LANE_W-1:0]    query_lane,
    output logic                 query_active,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WARP_ID_W-1:0] out_warp_id,
    output logic [WARP_SIZE-1:0] out_mask,
    output logic [CNT_W-1:0]     out_count,
    output logic [LANE_W-1:0]    out_first,
    output logic [LANE_W-1:0]    out_last,
    output logic                 out_any,
    output logic                 out_all,
    output logic [STAT_W-1:0]    stat_warps,
    output logic [STAT_W-1:0]    stat_lanes,
    input  logic                 stat_clr
);

    logic [CNT_W-1:0]  w_red_count;
    logic [LANE_W-1:0] w_red_first;
    logic [LANE_W-1:0] w_red_last;
    logic              w_red_any;
    logic              w_red_all;
    warp_payload_t     w_in_pl;
    logic [STAGES-1:0] w_adv;
    logic              w_xfer;
    logic              w_unused_bits;

    logic [STAGES-1:0] r_vld;
    warp_payload_t     r_pl [STAGES];

    warp_mask_reduce #(
        .WARP_SIZE (WARP_SIZE),
        .LANE_W    (LANE_W),
        .CNT_W     (CNT_W)
    ) u_reduce (
        .i_mask  (in_mask),
        .o_count (w_red_count),
        .o_first (w_red_first),
        .o_last  (w_red_last),
        .o_any   (w_red_any),
        .o_all   (w_red_all)
    );

    assign query_active = in_mask[query_lane];

    always_comb begin
        w_in_pl                          = '0;
        w_in_pl.warp_id[WARP_ID_W-1:0]   = in_warp_id;
        w_in_pl.mask[WARP_SIZE-1:0]      = in_mask;
        w_in_pl.count[CNT_W-1:0]         = w_red_count;
        w_in_pl.first[LANE_W-1:0]        = w_red_first;
        w_in_pl.last[LANE_W-1:0]         = w_red_last;
        w_in_pl.any                      = w_red_any;
        w_in_pl.all                      = w_red_all;
    end

    // Stage k may move iff some stage at or after k is empty, or the consumer takes the head.
    for (genvar g = 0; g < STAGES; g++) begin : g_adv
        assign w_adv[g] = out_ready || !(&r_vld[STAGES-1:g]);
    end

    assign in_ready = w_adv[0];
    assign w_xfer   = in_valid && w_adv[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int k = 0; k < STAGES; k++) r_pl[k] <= '0;
        end else begin
            if (w_adv[0]) r_vld[0] <= in_valid;
            if (w_xfer)   r_pl[0]  <= w_in_pl;
            for (int k = 1; k < STAGES; k++) begin
                if (w_adv[k])              r_vld[k] <= r_vld[k-1];
                if (w_adv[k] && r_vld[k-1]) r_pl[k]  <= r_pl[k-1];
            end
        end
    end

    assign out_valid   = r_vld[STAGES-1];
    assign out_warp_id = r_pl[STAGES-1].warp_id[WARP_ID_W-1:0];
    assign out_mask    = r_pl[STAGES-1].mask[WARP_SIZE-1:0];
    assign out_count   = r_pl[STAGES-1].count[CNT_W-1:0];
    assign out_first   = r_pl[STAGES-1].first[LANE_W-1:0];
    assign out_last    = r_pl[STAGES-1].last[LANE_W-1:0];
    assign out_any     = r_pl[STAGES-1].any;
    assign out_all     = r_pl[STAGES-1].all;

`ifdef WARP_MASK_STATS_EN
    logic [STAT_W-1:0] r_stat_warps;
    logic [STAT_W-1:0] r_stat_lanes;

    function automatic logic [STAT_W-1:0] f_sat_add(input logic [STAT_W-1:0] a,
                                                   input logic [STAT_W-1:0] b);
        logic [STAT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[STAT_W] ? {STAT_W{1'b1}} : s[STAT_W-1:0];
    endfunction

    // Clear takes priority over a coincident transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_warps <= '0;
            r_stat_lanes <= '0;
        end else if (stat_clr) begin
            r_stat_warps <= '0;
            r_stat_lanes <= '0;
        end else if (w_xfer) begin
            r_stat_warps <= f_sat_add(r_stat_warps, STAT_W'(1));
            r_stat_lanes <= f_sat_add(r_stat_lanes, STAT_W'(w_red_count));
        end
    end

    assign stat_warps    = r_stat_warps;
    assign stat_lanes    = r_stat_lanes;
    assign w_unused_bits = ^r_pl[STAGES-1];
`else
    assign stat_warps    = '0;
    assign stat_lanes    = '0;
    assign w_unused_bits = ^{r_pl[STAGES-1], stat_clr};
`endif

endmodule

// File: tb/tb_warp_mask_pipe_elastic.sv
// Self-checking bench for warp_mask_pipe_elastic against a queue-based reference model.
// Build with or without WARP_MASK_STATS_EN; expected stat values follow the macro.
module tb_warp_mask_pipe_elastic;

    localparam int WS  = 32;
    localparam int IDW = 4;
    localparam int ST  = 2;
    localparam int LW  = 5;
    localparam int CW  = 6;

    logic           clk, rst_n;
    logic           in_valid, in_ready, out_valid, out_ready;
    logic [IDW-1:0] in_warp_id, out_warp_id;
    logic [WS-1:0]  in_mask, out_mask;
    logic [LW-1:0]  query_lane, out_first, out_last;
    logic           query_active, out_any, out_all, stat_clr;
    logic [CW-1:0]  out_count;
    logic [31:0]    stat_warps, stat_lanes;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [WS-1:0]  mask;
        logic [CW-1:0]  count;
        logic [LW-1:0]  first;
        logic [LW-1:0]  last;
        logic           any;
        logic           all;
    } beat_t;

    beat_t  exp_q[$];
    beat_t  got_q[$];
    int     got_cyc[$];
    int     cyc;
    int     checks, failures;
    longint m_sw, m_sl;
    beat_t  obs;

    warp_mask_pipe_elastic #(.WARP_SIZE(WS), .WARP_ID_W(IDW), .STAGES(ST)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_warp_id(in_warp_id), .in_mask(in_mask),
        .query_lane(query_lane), .query_active(query_active),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_warp_id(out_warp_id), .out_mask(out_mask), .out_count(out_count),
        .out_first(out_first), .out_last(out_last), .out_any(out_any), .out_all(out_all),
        .stat_warps(stat_warps), .stat_lanes(stat_lanes), .stat_clr(stat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {out_warp_id, out_mask, out_count, out_first, out_last, out_any, out_all};

    function automatic beat_t ref_beat(input logic [IDW-1:0] id, input logic [WS-1:0] m);
        beat_t  b;
        longint mm;
        mm     = longint'(m);
        b.id   = id;
        b.mask = m;
        b.count = CW'($countones(m));
        b.any  = (m != 0);
        b.all  = (m == {WS{1'b1}});
        if (m == 0) begin
            b.first = '0;
            b.last  = '0;
        end else begin
            b.first = LW'($clog2(mm & -mm));
            b.last  = LW'($clog2(mm + 1) - 1);
        end
        return b;
    endfunction

    // Advance one clock; record accepted and delivered beats as seen on the ports.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            if (in_valid && in_ready) exp_q.push_back(ref_beat(in_warp_id, in_mask));
            if (out_valid && out_ready) begin
                got_q.push_back(obs);
                got_cyc.push_back(cyc);
            end
`ifdef WARP_MASK_STATS_EN
            if (stat_clr) begin
                m_sw = 0;
                m_sl = 0;
            end else if (in_valid && in_ready) begin
                m_sw = (m_sw + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sw + 1;
                m_sl = (m_sl + $countones(in_mask) > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF
                       : m_sl + $countones(in_mask);
            end
`endif
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
        m_sw = 0;
        m_sl = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_mask = $urandom;
        in_warp_id = IDW'($urandom);
        out_ready = 1'b0;
        #3;
        checks += 5;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (obs !== '0) begin failures++; $display("FAIL reset_out_data got=%h want=0", obs); end
        if (stat_warps !== 32'd0) begin failures++; $display("FAIL reset_stat_warps got=%0d want=0", stat_warps); end
        if (stat_lanes !== 32'd0) begin failures++; $display("FAIL reset_stat_lanes got=%0d want=0", stat_lanes); end
        repeat (2) @(posedge clk);
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_hold_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_hold_ready got=%b want=1", in_ready); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        beat_t e;
        clear_model();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_warp_id = 4'd3;
        in_mask = 32'h0000_00F0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b want=0", out_valid); end
        tick();
        e = ref_beat(4'd3, 32'h0000_00F0);
        checks += 5;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL single_latency got=%b want=1", out_valid); end
        if (obs !== e) begin failures++; $display("FAIL single_beat got=%h want=%h", obs, e); end
        if (out_count !== 6'd4) begin failures++; $display("FAIL single_count got=%0d want=4", out_count); end
        if (out_first !== 5'd4 || out_last !== 5'd7) begin
            failures++; $display("FAIL single_first_last got=%0d/%0d want=4/7", out_first, out_last);
        end
        if (out_any !== 1'b1 || out_all !== 1'b0 || out_warp_id !== 4'd3) begin
            failures++; $display("FAIL single_flags got any=%b all=%b id=%0d want 1 0 3", out_any, out_all, out_warp_id);
        end
        tick();
        checks++;
        if (got_q.size() != 1) begin failures++; $display("FAIL single_delivered got=%0d want=1", got_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [WS-1:0] m [3];
        m[0] = 32'h0;
        m[1] = 32'hFFFF_FFFF;
        m[2] = 32'h8000_0000;
        clear_model();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_warp_id = IDW'($urandom);
            in_mask = m[i];
            tick();
        end
        in_valid = 1'b0;
        repeat (ST + 2) tick();
        checks++;
        if (got_q.size() != 3 || exp_q.size() != 3) begin
            failures++; $display("FAIL b2b_count got=%0d want=3 (accepted %0d)", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks += 2;
                if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
                if (got_cyc[i] != got_cyc[0] + i) begin failures++; $display("FAIL b2b_consecutive%0d got=%0d want=%0d", i, got_cyc[i], got_cyc[0] + i); end
            end
            checks += 3;
            if (got_q[0].count !== 6'd0 || got_q[0].any !== 1'b0) begin
                failures++; $display("FAIL b2b_empty got count=%0d any=%b want 0 0", got_q[0].count, got_q[0].any);
            end
            if (got_q[1].count !== 6'd32 || got_q[1].all !== 1'b1 || got_q[1].last !== 5'd31 || got_q[1].first !== 5'd0) begin
                failures++; $display("FAIL b2b_full got count=%0d all=%b first=%0d last=%0d want 32 1 0 31",
                                     got_q[1].count, got_q[1].all, got_q[1].first, got_q[1].last);
            end
            if (got_q[2].first !== 5'd31 || got_q[2].last !== 5'd31) begin
                failures++; $display("FAIL b2b_single_lane got first=%0d last=%0d want 31 31", got_q[2].first, got_q[2].last);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WS-1:0] m [5];
        beat_t snap;
        int    guard;
        clear_model();
        for (int i = 0; i < 5; i++) m[i] = $urandom;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_warp_id = IDW'(exp_q.size());
            in_mask = m[exp_q.size() < 5 ? exp_q.size() : 4];
            #1;
            checks++;
            if (in_ready !== ((exp_q.size() - got_q.size()) < ST)) begin
                failures++; $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", c, in_ready, (exp_q.size() - got_q.size()) < ST);
            end
            tick();
        end
        checks += 3;
        if (exp_q.size() != ST) begin failures++; $display("FAIL bp_capacity got=%0d want=%0d", exp_q.size(), ST); end
        snap = obs;
        repeat (2) tick();
        if (obs !== snap || out_valid !== 1'b1) begin failures++; $display("FAIL bp_stable got=%h want=%h", obs, snap); end
        if (snap !== exp_q[0]) begin failures++; $display("FAIL bp_head got=%h want=%h", snap, exp_q[0]); end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_return got=%b want=1", in_ready); end
        guard = 0;
        while (exp_q.size() < 5 && guard < 20) begin
            in_valid = 1'b1;
            in_warp_id = IDW'(exp_q.size());
            in_mask = m[exp_q.size()];
            tick();
            guard++;
        end
        in_valid = 1'b0;
        repeat (ST + 2) tick();
        checks++;
        if (got_q.size() != 5 || exp_q.size() != 5) begin
            failures++; $display("FAIL bp_drain got=%0d want=5 (accepted %0d)", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_order%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_random();
        int mism;
        clear_model();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        m_sw = 0;
        m_sl = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in_warp_id = IDW'($urandom);
            case ($urandom_range(5))
                0: in_mask = '0;
                1: in_mask = '1;
                2: in_mask = 32'h1 << $urandom_range(31);
                default: in_mask = $urandom;
            endcase
            #1;
            checks++;
            if (in_ready !== (((exp_q.size() - got_q.size()) < ST) || out_ready)) begin
                failures++; $display("FAIL rand_in_ready cyc=%0d got=%b", c, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (ST + 2) tick();
        checks += 3;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        mism = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                if (mism < 5) $display("FAIL rand_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]);
                mism++;
            end
        end
        if (mism != 0) failures++;
        if (longint'(stat_warps) != m_sw || longint'(stat_lanes) != m_sl) begin
            failures++; $display("FAIL rand_stats got=%0d/%0d want=%0d/%0d", stat_warps, stat_lanes, m_sw, m_sl);
        end
    endtask

    task automatic test_query();
        clear_model();
        in_valid = 1'b0;
        out_ready = 1'b1;
        query_lane = 5'd5;
        for (int i = 0; i < 6; i++) begin
            in_mask = $urandom;
            in_mask[5] = (i % 2 == 1);
            #1;
            checks++;
            if (query_active !== (i % 2 == 1)) begin failures++; $display("FAIL query_lane5 step=%0d got=%b want=%b", i, query_active, i % 2 == 1); end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            query_lane = LW'($urandom);
            in_mask = $urandom;
            #1;
            checks++;
            if (query_active !== in_mask[query_lane]) begin
                failures++; $display("FAIL query_rand lane=%0d got=%b want=%b", query_lane, query_active, in_mask[query_lane]);
            end
        end
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++; $display("FAIL query_pipe_empty got valid=%b accepted=%0d want 0 0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        clear_model();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_warp_id = IDW'(i + 1);
            in_mask = $urandom | 32'h1;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_inflight got=%b want=1", out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_async got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        if (obs !== '0) begin failures++; $display("FAIL midrst_data got=%h want=0", obs); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        out_ready = 1'b1;
        repeat (ST + 3) tick();
        checks++;
        if (got_q.size() != 0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_stale got=%0d beats want=0", got_q.size());
        end
    endtask

    task automatic test_stats();
        logic [WS-1:0] m [3];
        longint want_w, want_l;
`ifdef WARP_MASK_STATS_EN
        want_w = 3;
        want_l = 36;
`else
        want_w = 0;
        want_l = 0;
`endif
        m[0] = 32'h0000_00F0;
        m[1] = 32'hFFFF_FFFF;
        m[2] = 32'h0;
        out_ready = 1'b1;
        in_valid = 1'b0;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_mask = m[i];
            tick();
        end
        in_valid = 1'b0;
        checks += 2;
        if (longint'(stat_warps) != want_w) begin failures++; $display("FAIL stats_warps got=%0d want=%0d", stat_warps, want_w); end
        if (longint'(stat_lanes) != want_l) begin failures++; $display("FAIL stats_lanes got=%0d want=%0d", stat_lanes, want_l); end
        stat_clr = 1'b1;
        in_valid = 1'b1;
        in_mask = 32'h0000_00F0;
        tick();
        stat_clr = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (stat_warps !== 32'd0 || stat_lanes !== 32'd0) begin
            failures++; $display("FAIL stats_clr_wins got=%0d/%0d want=0/0", stat_warps, stat_lanes);
        end
        repeat (ST + 2) tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_warp_id = '0;
        in_mask = '0;
        query_lane = '0;
        out_ready = 1'b0;
        stat_clr = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_query();
        test_reset_midflight();
        test_random();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
